mux_rr_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/mux_rr_arbiter_rr_pick.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 82 ++++++++
 tb/tb_mux_rr_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: FSM state encoding and select-width helper for mux_rr_arbiter.
package mux_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: first set request bit strictly after last, searching upward with wrap-around.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   last,
    output logic            any,
    output logic [SW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    // Walk from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        onehot = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) begin
                idx    = SW'((int'(last) + k) % NREQ);
                onehot = NREQ'(1) << ((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin NREQ:1 mux sequencer with a registered valid/ready output.
// Define MUX_ARB_LOCK_EN to let a requester keep the grant across transfers via req_lock.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = 8,
    localparam int SW   = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    input  logic               out_ready,
    output logic [SW-1:0]      sel,
    output logic               busy
);

    state_e          state_q, state_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SW-1:0]   sel_q, sel_d, last_q, last_d;
    logic            pick_any, accept, done;
    logic [SW-1:0]   pick_idx, grant_idx;
    logic [NREQ-1:0] pick_oh, grant_oh;

    rr_pick #(.NREQ(NREQ), .SW(SW)) u_pick (
        .req    (req_valid),
        .last   (last_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

`ifdef MUX_ARB_LOCK_EN
    logic lock_q, lock_d, use_lock;
    // A held lock only overrides round-robin while its owner still has data.
    assign use_lock  = lock_q && req_valid[sel_q];
    assign grant_idx = use_lock ? sel_q : pick_idx;
    assign grant_oh  = use_lock ? NREQ'(1) << sel_q : pick_oh;
    assign lock_d    = (state_q == ST_IDLE) ? (pick_any && req_lock[grant_idx]) : lock_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_d;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign grant_idx   = pick_idx;
    assign grant_oh    = pick_oh;
`endif

    assign accept     = (state_q == ST_IDLE) && pick_any;
    assign done       = (state_q == ST_HOLD) && out_ready;
    assign state_d    = accept ? ST_HOLD : done ? ST_IDLE : state_q;
    assign sel_d      = accept ? grant_idx : sel_q;
    assign out_data_d = accept ? req_data[int'(grant_idx)*DW +: DW] : out_data_q;
    assign last_d     = done ? sel_q : last_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            sel_q      <= '0;
            last_q     <= SW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
        end

    assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: randomized scoreboard bench for mux_rr_arbiter against a queue-based reference model.
module tb_mux_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int SW   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_lock = '0;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_ready = 1'b0;
    logic [SW-1:0]      sel;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [SW+DW-1:0] sb[$];
    bit               m_hold = 0;
    bit               m_lock = 0;
    int               m_last = NREQ - 1;
    int               m_sel = 0;
    int               w;
    logic [NREQ-1:0]  exp_rdy;

    mux_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Nearest valid requester after the previous grant, counting modulo NREQ.
    function automatic int rr_winner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Reference model: decides the grant for the upcoming edge and queues the expected word.
    always @(negedge clk) begin
        if (rst) begin
            m_hold = 0;
            m_lock = 0;
            m_last = NREQ - 1;
            m_sel  = 0;
            sb.delete();
        end else if (!m_hold) begin
            w = -1;
`ifdef MUX_ARB_LOCK_EN
            if (m_lock && req_valid[m_sel]) w = m_sel;
`endif
            if (w < 0) w = rr_winner(req_valid, m_last);
            exp_rdy = (w < 0) ? '0 : NREQ'(1) << w;
            check("req_ready_idle", int'(req_ready), int'(exp_rdy));
            check("out_valid_idle", int'(out_valid), 0);
            if (w >= 0) begin
                sb.push_back({SW'(w), req_data[w*DW +: DW]});
                m_hold = 1;
                m_sel  = w;
                m_lock = req_lock[w];
            end else begin
                m_lock = 0;
            end
        end else begin
            check("req_ready_hold", int'(req_ready), 0);
            check("busy_hold", int'(busy), 1);
            if (out_ready) begin
                m_hold = 0;
                m_last = m_sel;
            end
        end
    end

    // Monitor: every presented word must match the oldest queued expectation until it is taken.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got data %0h sel %0d expected no word", out_data, sel);
            end else begin
                check("out_data", int'(out_data), int'(sb[0][DW-1:0]));
                check("sel", int'(sel), int'(sb[0][DW +: SW]));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] v, input logic rdy, input logic [NREQ-1:0] lk);
        @(posedge clk);
        #1;
        req_valid = v;
        out_ready = rdy;
        req_lock  = lk;
        req_data  = $urandom;
    endtask

    initial begin
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        drive(4'b0001, 1'b1, 4'b0000);
        req_data[7:0] = 8'hA5;
        drive(4'b0000, 1'b1, 4'b0000);
        drive(4'b0000, 1'b1, 4'b0000);

        repeat (10) drive(4'b1111, 1'b1, 4'b0000);
        repeat (2) drive(4'b0000, 1'b1, 4'b0000);

        repeat (6) drive(4'b0111, 1'b1, 4'b0000);
        repeat (4) drive(4'b0101, 1'b1, 4'b0000);

        drive(4'b1111, 1'b1, 4'b0000);
        repeat (5) drive(4'b1111, 1'b0, 4'b0000);
        drive(4'b1111, 1'b1, 4'b0000);

        repeat (8) drive(4'b0011, 1'b1, 4'b0010);
        repeat (4) drive(4'b0001, 1'b1, 4'b0010);

        drive(4'b1111, 1'b0, 4'b0000);
        begin : wait_hold
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (busy) disable wait_hold;
            end
            checks++;
            errors++;
            $display("FAIL hold_timeout: busy stayed 0 expected 1");
        end
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #2;
        check("post_rst_first_grant", int'(req_ready), 1);

        repeat (600) drive(NREQ'($urandom), 1'(($urandom % 4) != 0), NREQ'($urandom));
        repeat (3) drive(4'b0000, 1'b1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
